// File: rtl/lms_multich_prefetch_fifo.sv
// Multi-channel first-word-fall-through FIFO: one shared write port steered by channel index,
// independent per-channel read ports with registered head word, level and status flags.
module lms_multich_prefetch_fifo #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned DEPTH_WIDTH = 6,
    parameter int unsigned CH_NUM      = 2,
    parameter int unsigned CH_WIDTH    = 1,
    parameter int unsigned AFULL_TH    = 56
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [CH_NUM-1:0]                 flush,
    input  logic                              wr_en,
    input  logic [CH_WIDTH-1:0]               wr_ch,
    input  logic [DATA_WIDTH-1:0]             wr_data,
    output logic [CH_NUM-1:0]                 wr_vld,
    input  logic [CH_NUM-1:0]                 rd_en,
    output logic [CH_NUM-1:0]                 rd_vld,
    output logic [CH_NUM*DATA_WIDTH-1:0]      rd_data,
    output logic [CH_NUM*(DEPTH_WIDTH+1)-1:0] level,
    output logic [CH_NUM-1:0]                 afull,
    output logic [CH_NUM-1:0]                 ovf
);

    localparam int unsigned DEPTH = 1 << DEPTH_WIDTH;
    localparam int unsigned LVL_W = DEPTH_WIDTH + 1;

    for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
        logic [DATA_WIDTH-1:0]  mem [DEPTH];
        logic [DEPTH_WIDTH-1:0] wr_ptr;
        logic [DEPTH_WIDTH-1:0] rd_ptr;
        logic [DEPTH_WIDTH-1:0] head_addr;
        logic [LVL_W-1:0]       lvl;
        logic [LVL_W-1:0]       lvl_nxt;
        logic [DATA_WIDTH-1:0]  head_nxt;
        logic [DATA_WIDTH-1:0]  rd_data_q;
        logic                   wr_hit;
        logic                   wr_acc;
        logic                   rd_acc;
        logic                   wr_vld_q;
        logic                   rd_vld_q;
        logic                   afull_q;
        logic                   ovf_q;

        // Accept/pop decisions, next level, and the word that will be at the head after this edge
        always_comb begin
            wr_hit    = wr_en && (wr_ch == CH_WIDTH'(k));
            wr_acc    = wr_hit && wr_vld_q && !flush[k];
            rd_acc    = rd_en[k] && rd_vld_q && !flush[k];
            lvl_nxt   = lvl;
            if (flush[k]) begin
                lvl_nxt = '0;
            end else if (wr_acc && !rd_acc) begin
                lvl_nxt = lvl + LVL_W'(1);
            end else if (rd_acc && !wr_acc) begin
                lvl_nxt = lvl - LVL_W'(1);
            end
            head_addr = rd_ptr + DEPTH_WIDTH'(rd_acc);
            // The new head may be the word being written this same edge
            head_nxt  = (wr_acc && (head_addr == wr_ptr)) ? wr_data : mem[head_addr];
        end

        always_ff @(posedge clk) begin
            if (wr_acc) begin
                mem[wr_ptr] <= wr_data;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                lvl       <= '0;
                rd_data_q <= '0;
                wr_vld_q  <= 1'b1;
                rd_vld_q  <= 1'b0;
                afull_q   <= 1'b0;
                ovf_q     <= 1'b0;
            end else begin
                lvl      <= lvl_nxt;
                wr_vld_q <= (lvl_nxt != LVL_W'(DEPTH));
                rd_vld_q <= (lvl_nxt != '0);
                afull_q  <= (lvl_nxt >= LVL_W'(AFULL_TH));
                if (flush[k]) begin
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                    ovf_q  <= 1'b0;
                end else begin
                    wr_ptr <= wr_ptr + DEPTH_WIDTH'(wr_acc);
                    rd_ptr <= rd_ptr + DEPTH_WIDTH'(rd_acc);
                    if (wr_hit && !wr_vld_q) begin
                        ovf_q <= 1'b1;
                    end
                    if (lvl_nxt != '0) begin
                        rd_data_q <= head_nxt;
                    end
                end
            end
        end

        assign wr_vld[k]                             = wr_vld_q;
        assign rd_vld[k]                             = rd_vld_q;
        assign afull[k]                              = afull_q;
        assign ovf[k]                                = ovf_q;
        assign rd_data[k*DATA_WIDTH +: DATA_WIDTH]   = rd_data_q;
        assign level[k*LVL_W +: LVL_W]               = lvl;
    end

endmodule

// File: tb/tb_lms_multich_prefetch_fifo.sv
// Directed self-checking bench for lms_multich_prefetch_fifo (2 channels, 16-bit, depth 64).
module tb_lms_multich_prefetch_fifo;

    logic        clk;
    logic        rst_n;
    logic [1:0]  flush;
    logic        wr_en;
    logic [1:0]  wr_ch;
    logic [15:0] wr_data;
    logic [1:0]  wr_vld;
    logic [1:0]  rd_en;
    logic [1:0]  rd_vld;
    logic [31:0] rd_data;
    logic [13:0] level;
    logic [1:0]  afull;
    logic [1:0]  ovf;

    int n_cmp;
    int n_err;
    logic [15:0] exp_q[$];

    lms_multich_prefetch_fifo #(
        .DATA_WIDTH (16),
        .DEPTH_WIDTH(6),
        .CH_NUM     (2),
        .CH_WIDTH   (2),
        .AFULL_TH   (56)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .flush  (flush),
        .wr_en  (wr_en),
        .wr_ch  (wr_ch),
        .wr_data(wr_data),
        .wr_vld (wr_vld),
        .rd_en  (rd_en),
        .rd_vld (rd_vld),
        .rd_data(rd_data),
        .level  (level),
        .afull  (afull),
        .ovf    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        rst_n   = 1'b0;
        flush   = 2'b00;
        wr_en   = 1'b0;
        wr_ch   = 2'd0;
        wr_data = 16'h0;
        rd_en   = 2'b00;
        #23;
        chk("rst_wr_vld", wr_vld, 2'b11);
        chk("rst_rd_vld", rd_vld, 2'b00);
        chk("rst_level", level, 14'd0);
        chk("rst_rd_data", rd_data, 32'h0);
        chk("rst_flags", {afull, ovf}, 4'b0000);
        rst_n = 1'b1;
        tick();

        // Write into empty ch0: visible next cycle
        wr_en = 1'b1; wr_ch = 2'd0; wr_data = 16'h1234;
        tick();
        wr_en = 1'b0;
        chk("t1_rd_vld", rd_vld, 2'b01);
        chk("t1_rd_data0", rd_data[15:0], 16'h1234);
        chk("t1_level0", level[6:0], 7'd1);

        // Fill ch1 to 64, afull from 56th write on
        wr_ch = 2'd1;
        for (int i = 0; i < 64; i++) begin
            wr_en = 1'b1; wr_data = 16'h0100 + 16'(i);
            tick();
            if (i == 54) chk("t2_afull_55", afull[1], 1'b0);
            if (i == 55) chk("t2_afull_56", afull[1], 1'b1);
        end
        chk("t2_wr_vld_full", wr_vld, 2'b01);
        chk("t2_level1_64", level[13:7], 7'd64);
        chk("t2_ovf_before", ovf, 2'b00);
        wr_data = 16'hDEAD;
        tick();
        wr_en = 1'b0;
        chk("t2_ovf1", ovf, 2'b10);
        chk("t2_level1_hold", level[13:7], 7'd64);
        chk("t2_head1", rd_data[31:16], 16'h0100);

        // Full ch1: pop and write together -> pop wins, write rejected, ovf set
        wr_en = 1'b1; wr_ch = 2'd1; wr_data = 16'hBEEF; rd_en = 2'b10;
        tick();
        wr_en = 1'b0; rd_en = 2'b00;
        chk("t5_level1_63", level[13:7], 7'd63);
        chk("t5_ovf1", ovf[1], 1'b1);
        chk("t5_head1", rd_data[31:16], 16'h0101);
        chk("t5_afull1", afull[1], 1'b1);
        chk("t5_wr_vld1", wr_vld[1], 1'b1);
        flush = 2'b10;
        tick();
        flush = 2'b00;
        chk("t5_flush_level1", level[13:7], 7'd0);
        chk("t5_flush_ovf", ovf, 2'b00);
        chk("t5_flush_rd_vld", rd_vld, 2'b01);
        chk("t5_flush_afull", afull, 2'b00);
        chk("t5_ch0_level", level[6:0], 7'd1);
        chk("t5_ch0_data", rd_data[15:0], 16'h1234);

        // Drain ch0, then an extra rd_en on empty is ignored and data holds
        rd_en = 2'b01;
        tick();
        chk("t4_drain_level0", level[6:0], 7'd0);
        tick();
        rd_en = 2'b00;
        chk("t4_underflow_level0", level[6:0], 7'd0);
        chk("t4_rd_vld_empty", rd_vld, 2'b00);
        chk("t4_rd_data_hold", rd_data[15:0], 16'h1234);

        // Empty ch0 write + rd_en same cycle -> write accepted, read ignored
        wr_en = 1'b1; wr_ch = 2'd0; wr_data = 16'hA5A5; rd_en = 2'b01;
        tick();
        wr_en = 1'b0; rd_en = 2'b00;
        chk("t4_level0", level[6:0], 7'd1);
        chk("t4_rd_data0", rd_data[15:0], 16'hA5A5);
        chk("t4_rd_vld", rd_vld, 2'b01);

        // Bring ch0 to level 10, then write+pop for 200 cycles across pointer wrap
        exp_q.push_back(16'hA5A5);
        for (int i = 0; i < 9; i++) begin
            wr_en = 1'b1; wr_ch = 2'd0; wr_data = 16'h2000 + 16'(i);
            exp_q.push_back(wr_data);
            tick();
        end
        chk("t3_level0_10", level[6:0], 7'd10);
        for (int i = 9; i < 209; i++) begin
            chk("t3_rd_vld0", rd_vld[0], 1'b1);
            chk("t3_head0", rd_data[15:0], exp_q[0]);
            wr_en = 1'b1; wr_ch = 2'd0; wr_data = 16'h2000 + 16'(i); rd_en = 2'b01;
            exp_q.push_back(wr_data);
            void'(exp_q.pop_front());
            tick();
        end
        wr_en = 1'b0; rd_en = 2'b00;
        chk("t3_level0_end", level[6:0], 7'd10);
        chk("t3_head0_end", rd_data[15:0], exp_q[0]);

        // Burst into ch1, async reset between edges
        wr_en = 1'b1; wr_ch = 2'd1; wr_data = 16'h7777;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_level", level, 14'd0);
        chk("t6_async_rd_vld", rd_vld, 2'b00);
        chk("t6_async_wr_vld", wr_vld, 2'b11);
        chk("t6_async_rd_data", rd_data, 32'h0);
        wr_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Out-of-range channel writes are ignored
        wr_en = 1'b1; wr_ch = 2'd3; wr_data = 16'h5555;
        tick();
        wr_ch = 2'd2;
        tick();
        wr_en = 1'b0;
        chk("t6_bad_ch_level", level, 14'd0);
        chk("t6_bad_ch_flags", {wr_vld, rd_vld, afull, ovf}, 8'b1100_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
